// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes,
// function codes, ALU sub-op and result-class encodings.
package id_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [7:0] {
    EXE_NOP_OP = 8'h00,
    EXE_SRL_OP = 8'h02,
    EXE_SRA_OP = 8'h03,
    EXE_AND_OP = 8'h24,
    EXE_OR_OP  = 8'h25,
    EXE_XOR_OP = 8'h26,
    EXE_NOR_OP = 8'h27,
    EXE_LUI_OP = 8'h5C,
    EXE_SLL_OP = 8'h7C
  } aluop_e;

  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'd0,
    EXE_RES_LOGIC = 3'd1,
    EXE_RES_SHIFT = 3'd2
  } alusel_e;

endpackage

// File: rtl/id_stage_decode.sv
// Combinational decoder for the logic-imm, logic-reg and
// shift subset; flags anything else as illegal.
module id_stage_decode
  import id_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LUI_SHIFT = 16
) (
  input  logic [31:0]       inst_i,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic              re1_o,
  output logic              re2_o,
  output logic [ADDR_W-1:0] raddr1_o,
  output logic [ADDR_W-1:0] raddr2_o,
  output logic [DATA_W-1:0] imm1_o,
  output logic [DATA_W-1:0] imm2_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wreg_o,
  output logic              illegal_o
);

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] zimm;
  logic [DATA_W-1:0] sa;
  logic              wen;

  assign op   = inst_i[31:26];
  assign fn   = inst_i[5:0];
  assign rs   = ADDR_W'(inst_i[25:21]);
  assign rt   = ADDR_W'(inst_i[20:16]);
  assign rd   = ADDR_W'(inst_i[15:11]);
  assign zimm = DATA_W'(inst_i[15:0]);
  assign sa   = DATA_W'(inst_i[10:6]);

  always_comb begin
    aluop_o   = EXE_NOP_OP;
    alusel_o  = EXE_RES_NOP;
    re1_o     = 1'b0;
    re2_o     = 1'b0;
    raddr1_o  = '0;
    raddr2_o  = '0;
    imm1_o    = '0;
    imm2_o    = '0;
    waddr_o   = '0;
    wen       = 1'b0;
    illegal_o = 1'b0;
    unique case (1'b1)
      op == OP_ORI,
      op == OP_ANDI,
      op == OP_XORI: begin
        re1_o    = 1'b1;
        raddr1_o = rs;
        imm2_o   = zimm;
        waddr_o  = rt;
        wen      = 1'b1;
        alusel_o = EXE_RES_LOGIC;
        unique case (1'b1)
          op == OP_ANDI: aluop_o = EXE_AND_OP;
          op == OP_XORI: aluop_o = EXE_XOR_OP;
          default:       aluop_o = EXE_OR_OP;
        endcase
      end
      op == OP_LUI: begin
        imm2_o   = zimm << LUI_SHIFT;
        waddr_o  = rt;
        wen      = 1'b1;
        alusel_o = EXE_RES_LOGIC;
        aluop_o  = EXE_OR_OP;
      end
      op == OP_SPECIAL: begin
        unique case (1'b1)
          fn == FN_AND, fn == FN_OR,
          fn == FN_XOR, fn == FN_NOR: begin
            re1_o    = 1'b1;
            re2_o    = 1'b1;
            raddr1_o = rs;
            raddr2_o = rt;
            waddr_o  = rd;
            wen      = 1'b1;
            alusel_o = EXE_RES_LOGIC;
            aluop_o  = fn;
          end
          fn == FN_SLL, fn == FN_SRL,
          fn == FN_SRA: begin
            re2_o    = 1'b1;
            raddr2_o = rt;
            imm1_o   = sa;
            waddr_o  = rd;
            wen      = 1'b1;
            alusel_o = EXE_RES_SHIFT;
            unique case (1'b1)
              fn == FN_SRL: aluop_o = EXE_SRL_OP;
              fn == FN_SRA: aluop_o = EXE_SRA_OP;
              default:      aluop_o = EXE_SLL_OP;
            endcase
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // $0 is hardwired, so any write aimed at it is dropped here.
  assign wreg_o = wen & (waddr_o != '0);

endmodule

// File: rtl/id_stage.sv
// ID stage: decode, EX/MEM forwarding, load-use stall and
// the ID/EX register behind a valid/ready handshake.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PC_W      = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [ADDR_W-1:0] reg1_addr_o,
  output logic [ADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_data_o,
  output logic [DATA_W-1:0] reg2_data_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wreg_o,
  output logic              illegal_o
);

  logic [7:0]        d_aluop;
  logic [2:0]        d_alusel;
  logic              d_re1;
  logic              d_re2;
  logic [ADDR_W-1:0] d_ra1;
  logic [ADDR_W-1:0] d_ra2;
  logic [DATA_W-1:0] d_imm1;
  logic [DATA_W-1:0] d_imm2;
  logic [ADDR_W-1:0] d_waddr;
  logic              d_wreg;
  logic              d_illegal;

  id_stage_decode #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LUI_SHIFT(LUI_SHIFT)
  ) u_dec (
    .inst_i   (inst_i),
    .aluop_o  (d_aluop),
    .alusel_o (d_alusel),
    .re1_o    (d_re1),
    .re2_o    (d_re2),
    .raddr1_o (d_ra1),
    .raddr2_o (d_ra2),
    .imm1_o   (d_imm1),
    .imm2_o   (d_imm2),
    .waddr_o  (d_waddr),
    .wreg_o   (d_wreg),
    .illegal_o(d_illegal)
  );

  assign reg1_read_o = rst & d_re1;
  assign reg2_read_o = rst & d_re2;
  assign reg1_addr_o = rst ? d_ra1 : '0;
  assign reg2_addr_o = rst ? d_ra2 : '0;

  function automatic logic [DATA_W-1:0] sel_op(
    input logic              re,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] rf,
    input logic              ex_we,
    input logic [ADDR_W-1:0] ex_a,
    input logic [DATA_W-1:0] ex_d,
    input logic              mem_we,
    input logic [ADDR_W-1:0] mem_a,
    input logic [DATA_W-1:0] mem_d
  );
    if (!re)                         return imm;
    else if (addr == '0)             return '0;
    else if (ex_we && ex_a == addr)  return ex_d;
    else if (mem_we && mem_a == addr) return mem_d;
    else                             return rf;
  endfunction

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              hazard;
  logic              capture;

  assign op1 = sel_op(d_re1, d_ra1, d_imm1, reg1_data_i,
                      ex_wreg_i, ex_waddr_i, ex_wdata_i,
                      mem_wreg_i, mem_waddr_i, mem_wdata_i);
  assign op2 = sel_op(d_re2, d_ra2, d_imm2, reg2_data_i,
                      ex_wreg_i, ex_waddr_i, ex_wdata_i,
                      mem_wreg_i, mem_waddr_i, mem_wdata_i);

  // Loaded data is not ready until MEM, so forwarding cannot cover it.
  assign hazard = in_valid & ex_is_load_i & ex_wreg_i &
                  ((d_re1 & (d_ra1 != '0) & (d_ra1 == ex_waddr_i)) |
                   (d_re2 & (d_ra2 != '0) & (d_ra2 == ex_waddr_i)));

  logic valid_q, valid_d;

  assign in_ready = rst & ~hazard & ~flush_i & (~valid_q | out_ready);
  assign capture  = in_valid & in_ready;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] r1_q, r1_d;
  logic [DATA_W-1:0] r2_q, r2_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wreg_q, wreg_d;
  logic              ill_q, ill_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    waddr_d  = waddr_q;
    wreg_d   = wreg_q;
    ill_d    = ill_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d  = 1'b1;
      pc_d     = pc_i;
      aluop_d  = d_aluop;
      alusel_d = d_alusel;
      r1_d     = op1;
      r2_d     = op2;
      waddr_d  = d_waddr;
      wreg_d   = d_wreg;
      ill_d    = d_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      aluop_q  <= '0;
      alusel_q <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      waddr_q  <= '0;
      wreg_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      waddr_q  <= waddr_d;
      wreg_q   <= wreg_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign pc_o        = pc_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_data_o = r1_q;
  assign reg2_data_o = r2_q;
  assign waddr_o     = waddr_q;
  assign wreg_o      = wreg_q;
  assign illegal_o   = ill_q;

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined, parametrised instruction-decode stage. It sits between the IF/ID register and the EX stage. It decodes the logical-immediate, logical-register and shift subset, reads operands from regfile with EX/MEM forwarding, and detects load-use hazards. Results are registered in an internal ID/EX output register behind a valid/ready handshake. Unlike the single-cycle combinational decoder it replaces, it holds state, stalls, flushes, and flags illegal opcodes.

## Interface
Parameters:
- DATA_W, 32, operand/data width; immediates are extended to DATA_W
- ADDR_W, 5, register address width
- PC_W, 32, pc width
- LUI_SHIFT, 16, left shift applied to imm16 for LUI; must be < DATA_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts an instruction this cycle
- pc_i  in  PC_W  instruction address
- inst_i  in  32  instruction word
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  ADDR_W  regfile read addresses (combinational)
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle
- ex_wreg_i, ex_waddr_i, ex_wdata_i, ex_is_load_i  in  1/ADDR_W/DATA_W/1  EX-stage writeback info
- mem_wreg_i, mem_waddr_i, mem_wdata_i  in  1/ADDR_W/DATA_W  MEM-stage writeback info
- flush_i  in  1  discard the held and incoming instruction
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts it
- pc_o  out  PC_W  registered pc
- aluop_o  out  8  registered ALU sub-op
- alusel_o  out  3  registered result class
- reg1_data_o / reg2_data_o  out  DATA_W  registered source operands
- waddr_o  out  ADDR_W  registered destination register
- wreg_o  out  1  registered write enable
- illegal_o  out  1  registered illegal-instruction flag

## Operation
Decode (combinational):
- ORI 0x0D, ANDI 0x0C, XORI 0x0E: read rs; op2 = zero-extended imm16; dest rt.
- LUI 0x0F: no register reads; op1 = 0, op2 = imm16 << LUI_SHIFT; dest rt; aluop OR.
- SPECIAL 0x00, func 0x24/0x25/0x26/0x27 (AND/OR/XOR/NOR): read rs and rt; dest rd.
- SPECIAL func 0x00/0x02/0x03 (SLL/SRL/SRA): read rt only; op1 = zero-extended sa field (inst[10:6]); dest rd.
- Any other opcode or func: aluop NOP, alusel NOP, wreg = 0, illegal = 1, no reads.
- Instruction word 0 decodes as SLL $0 and must leave wreg = 0, since writes to address 0 are suppressed.
- Any decoded destination of 0 forces wreg = 0.

Operand select, per source, highest priority first:
1. read disabled: use the immediate/sa value, or 0.
2. address 0: use 0.
3. ex_wreg_i and ex_waddr_i match: use ex_wdata_i.
4. mem_wreg_i and mem_waddr_i match: use mem_wdata_i.
5. Otherwise use the regfile data.

Hazard and handshake:
- hazard = in_valid & ex_is_load_i & ex_wreg_i & (an enabled nonzero read address equals ex_waddr_i).
- in_ready = ~hazard & ~flush_i & (~out_valid | out_ready).
- Capture occurs when in_valid & in_ready; out_valid becomes 1.
- If out_ready and no capture, out_valid becomes 0 (bubble); payload may hold stale values.
- If out_valid & ~out_ready, all outputs hold unchanged.
- flush_i has priority over everything: out_valid becomes 0 next edge and nothing is captured.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 instruction per cycle with no hazard.
- A load-use hazard inserts exactly one bubble; capture happens the cycle after ex_is_load_i drops.
- Read enables and addresses are valid in the same cycle as inst_i; regfile data is expected in that same cycle.
- Reset (asynchronous assert): out_valid = 0, wreg_o = 0, illegal_o = 0, and every other registered output = 0 (aluop/alusel = NOP encodings = 0).
- Reset mid-stall discards the held instruction.
- Combinational outputs during reset: read enables = 0, addresses = 0, in_ready = 0.

## Structure
- Add to defines.v: opcode/func constants, EXE_AND/XOR/NOR/LUI/SLL/SRL/SRA_OP, EXE_RES_SHIFT, and NOP encodings of 0.
- Sub-module id_decode: pure combinational decoder producing aluop, alusel, read enables/addresses, the immediate, dest, wreg and illegal.
- id_stage owns forwarding, hazard detection, handshake and the output register.

## Test plan
- Reset, then ORI with rs=1 (regfile 0x0000_F000), imm 0x00FF -> next cycle out_valid = 1, reg1 = 0x0000_F000, reg2 = 0x0000_00FF, waddr = rt, wreg = 1.
- OR $3,$1,$2 with EX writing $1 = 0xAAAA_0000 and MEM writing $1 = 0x1111 -> reg1 = 0xAAAA_0000 (EX wins); then with EX idle -> reg1 = 0x1111.
- ex_is_load_i = 1, ex_waddr = 2, with AND reading $2 -> in_ready = 0 for one cycle, one bubble (out_valid = 0), then captured with the forwarded value.
- out_ready held low for 3 cycles with in_valid high -> outputs stable and in_ready = 0; on release the next instruction is captured.
- Opcode 0x3F -> illegal_o = 1, wreg_o = 0; LUI 0x1234 -> reg2 = 0x1234_0000; instruction word 0 -> wreg_o = 0.
- flush_i asserted with out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, nothing captured; rst low mid-stall -> all outputs 0 immediately.
